tdc_hw_accum: RTL
=================

// Module: tdc_hw_accum
// PURPOSE
//  Downstream consumer of the TDC hamming-weight (hw) output. Collects a window of
//  2**LOG2_WIN hw samples and computes sum, mean, min and max over the window.
//  Emits the result as a 6-byte frame over a valid/ready byte stream toward the
//  chip output pins, replacing raw per-sample hw readout with on-chip statistics.
// PARAMETERS
//  N         64  delay-line length; legal hw range is 0..N
//  HW_W      $clog2(N)+1 (7)  width of hw_in
//  LOG2_WIN  8   log2 of samples per window; HW_W+LOG2_WIN must be <= 16
//  HDR       8'hA5  frame header byte
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous active-low reset
//  hw_in      in   HW_W  hamming weight from TDC, valid when hw_valid=1
//  hw_valid   in   1     1-cycle sample strobe, synchronous to clk
//  start      in   1     1-cycle pulse: begin a new window (honoured in IDLE only)
//  abort      in   1     synchronous abort from any state
//  out_data   out  8     frame byte
//  out_valid  out  1     out_data valid
//  out_ready  in   1     consumer accepts byte when out_valid&&out_ready
//  busy       out  1     1 in ACCUM or SEND
//  done       out  1     1-cycle pulse after last frame byte accepted
//  range_err  out  1     sticky: a sample with hw_in>N was seen this window
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; sum=0, min=N, max=0, count=0, byte_idx=0;
//   out_data=0, out_valid=0, busy=0, done=0, range_err=0.
//  States: IDLE -> ACCUM -> SEND -> IDLE. All outputs registered.
//  IDLE: start=1 at cycle t -> clear sum=0, min=N, max=0, count=0, range_err=0;
//   ACCUM from t+1. hw_valid in IDLE ignored (incl. same cycle as start).
//  ACCUM: each hw_valid: s = (hw_in>N) ? N : hw_in; hw_in>N sets range_err.
//   sum+=s; min=min(min,s); max=max(max,s); count++. start ignored.
//   Sum width SUM_W=HW_W+LOG2_WIN; cannot overflow (max N*2**LOG2_WIN).
//  Window end: sample number 2**LOG2_WIN accepted at cycle k -> statistics
//   (including that sample) latched into frame regs; SEND with out_valid=1 at k+1.
//  Frame order (byte_idx 0..5): HDR, MEAN=sum>>LOG2_WIN (truncating),
//   MIN, MAX, SUM[7:0], SUM[15:8] (sum zero-extended to 16 bits).
//  SEND: byte advances on out_valid&&out_ready; out_data/out_valid held stable while
//   out_ready=0. Accepting byte 5 -> out_valid=0, done=1 for one cycle, IDLE next.
//   hw_valid in SEND ignored (samples dropped). start ignored.
//  abort=1 (any state): IDLE next cycle, out_valid=0, busy=0, no done, partial
//   window discarded; range_err keeps value until next start. abort beats start.
//  out_valid never deasserts in SEND without a handshake, except on abort/reset.
//  Reset mid-operation: outputs clear immediately; no frame resumes after release.
//  count width LOG2_WIN+1; wrap impossible since window ends exactly at 2**LOG2_WIN.
// TESTING
//  1 LOG2_WIN=2: start; hw 10,20,30,40 with gaps -> frame A5,19,0A,28,64,00; done=1.
//  2 Default params, 256 samples all 64 -> A5,40,40,40,00,40 (sum=0x4000).
//  3 Backpressure: out_ready=0 for 5 cycles at byte 2 -> out_data holds MIN,
//    out_valid=1; exactly 6 bytes accepted, none duplicated or lost.
//  4 LOG2_WIN=2: samples 70,0,5,5 (N=64) -> range_err=1, MIN=00, MAX=40, SUM=0x4A,
//    MEAN=0x12.
//  5 abort after 2 samples -> IDLE next cycle, busy=0, no out_valid; new start with
//    4x hw=8 -> A5,08,08,08,20,00.
//  6 rst_n low during SEND byte 3 -> out_valid=0, busy=0 same cycle (async);
//    after release only a fresh start produces a frame; start+abort together -> IDLE.

Source files
------------

// File: rtl/tdc_hw_accum.sv
// Window statistics (sum/mean/min/max) over TDC hamming-weight samples.
// Ports: clk, rst_n, hw_in/hw_valid samples, start/abort control,
//        out_data/out_valid/out_ready byte stream, busy, done, range_err.
module tdc_hw_accum #(
  parameter int          N        = 64,
  parameter int          HW_W     = $clog2(N) + 1,
  parameter int          LOG2_WIN = 8,
  parameter logic [7:0]  HDR      = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HW_W-1:0] hw_in,
  input  logic            hw_valid,
  input  logic            start,
  input  logic            abort,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            range_err
);

  localparam int SUM_W = HW_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [HW_W-1:0]  NV   = HW_W'(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_WIN) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SEND
  } state_t;

  state_t            r_state, w_state;
  logic [SUM_W-1:0]  r_sum, w_sum;
  logic [HW_W-1:0]   r_min, w_min;
  logic [HW_W-1:0]   r_max, w_max;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [2:0]        r_idx, w_idx;
  logic [7:0]        r_data, w_data;
  logic              r_valid, w_valid;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_rerr, w_rerr;

  logic              w_ovr;
  logic [HW_W-1:0]   w_s;
  logic [2:0]        w_idx_inc;
  logic [15:0]       w_sum16;
  logic [7:0]        w_mean;
  logic [7:0]        w_nbyte;

  // Out-of-range samples are clamped to N before they touch the statistics
  assign w_ovr     = (hw_in > NV);
  assign w_s       = w_ovr ? NV : hw_in;
  assign w_idx_inc = r_idx + 3'd1;
  assign w_sum16   = 16'(r_sum);
  assign w_mean    = 8'(r_sum >> LOG2_WIN);

  // Accumulators are frozen in SEND, so they double as the frame registers
  always_comb begin
    w_nbyte = 8'h00;
    case (w_idx_inc)
      3'd1:    w_nbyte = w_mean;
      3'd2:    w_nbyte = 8'(r_min);
      3'd3:    w_nbyte = 8'(r_max);
      3'd4:    w_nbyte = w_sum16[7:0];
      3'd5:    w_nbyte = w_sum16[15:8];
      default: w_nbyte = 8'h00;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_sum   = r_sum;
    w_min   = r_min;
    w_max   = r_max;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_data  = r_data;
    w_valid = r_valid;
    w_rerr  = r_rerr;
    w_done  = 1'b0;
    if (abort) begin
      w_state = S_IDLE;
      w_valid = 1'b0;
      w_idx   = 3'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state = S_ACCUM;
            w_sum   = '0;
            w_min   = NV;
            w_max   = '0;
            w_cnt   = '0;
            w_rerr  = 1'b0;
          end
        end
        S_ACCUM: begin
          if (hw_valid) begin
            w_sum = r_sum + SUM_W'(w_s);
            w_cnt = r_cnt + CNT_W'(1);
            if (w_s < r_min) w_min = w_s;
            if (w_s > r_max) w_max = w_s;
            if (w_ovr) w_rerr = 1'b1;
            if (r_cnt == LAST) begin
              w_state = S_SEND;
              w_valid = 1'b1;
              w_data  = HDR;
              w_idx   = 3'd0;
            end
          end
        end
        S_SEND: begin
          if (r_valid && out_ready) begin
            if (r_idx == 3'd5) begin
              w_state = S_IDLE;
              w_valid = 1'b0;
              w_done  = 1'b1;
              w_idx   = 3'd0;
            end else begin
              w_idx  = w_idx_inc;
              w_data = w_nbyte;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sum   <= '0;
      r_min   <= NV;
      r_max   <= '0;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sum   <= w_sum;
      r_min   <= w_min;
      r_max   <= w_max;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rerr  <= w_rerr;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_rerr;

endmodule
